// File: rtl/parity_frame_checker_if.sv
// Serial-bit input and frame-result output handshake bundle of the parity frame checker.
interface parity_frame_checker_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err;

  modport master (
    output in_valid,
    output in_bit,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_bit,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );
endinterface

// File: rtl/parity_frame_checker.sv
// Receive-side serial frame checker: assembles DATA_W data bits (LSB first), checks the
// trailing parity bit, presents word + error flag on a valid/ready handshake, counts bad frames.
module parity_frame_checker #(
  parameter int DATA_W    = 8,
  parameter bit ODD       = 1'b0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_frame_checker_if.slave bus,
  input  logic                 abort,
  input  logic                 clr_cnt,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    RECV = 2'd0,
    PAR  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic parity_error(input logic acc, input logic p, input logic odd);
    return acc ^ p ^ odd;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ERR_CNT_W'(1);
    end
  endfunction

  state_t                state_r, state_s;
  logic                  acc_r, acc_s;
  logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
  logic [DATA_W-1:0]     word_r, word_s;
  logic [DATA_W-1:0]     out_data_r, out_data_s;
  logic                  out_err_r, out_err_s;
  logic [ERR_CNT_W-1:0]  err_count_r, err_count_s;
  logic                  in_ready_s;
  logic                  accept_s;
  logic                  frame_err_s;
  logic                  count_inc_s;

  assign in_ready_s  = (state_r != OUT);
  assign accept_s    = bus.in_valid && in_ready_s;
  assign frame_err_s = parity_error(acc_r, bus.in_bit, ODD);

  // Next-state, frame assembly and result capture; abort overrides every other event.
  always_comb begin
    state_s     = state_r;
    acc_s       = acc_r;
    bit_cnt_s   = bit_cnt_r;
    word_s      = word_r;
    out_data_s  = out_data_r;
    out_err_s   = out_err_r;
    count_inc_s = 1'b0;
    if (abort) begin
      state_s   = RECV;
      acc_s     = 1'b0;
      bit_cnt_s = '0;
    end else begin
      case (state_r)
        RECV: begin
          if (accept_s) begin
            acc_s             = acc_r ^ bus.in_bit;
            word_s[bit_cnt_r] = bus.in_bit;
            if (bit_cnt_r == LAST_BIT) begin
              state_s   = PAR;
              bit_cnt_s = '0;
            end else begin
              bit_cnt_s = bit_cnt_r + CNT_W'(1);
            end
          end else begin
            state_s = RECV;
          end
        end
        PAR: begin
          if (accept_s) begin
            out_err_s   = frame_err_s;
            out_data_s  = word_r;
            count_inc_s = frame_err_s;
            state_s     = OUT;
          end else begin
            state_s = PAR;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            state_s   = RECV;
            acc_s     = 1'b0;
            bit_cnt_s = '0;
          end else begin
            state_s = OUT;
          end
        end
        default: begin
          state_s   = RECV;
          acc_s     = 1'b0;
          bit_cnt_s = '0;
        end
      endcase
    end
  end

  // Error counter update; a clear wins over the increment of the same frame.
  always_comb begin
    err_count_s = err_count_r;
    if (clr_cnt) begin
      err_count_s = '0;
    end else if (count_inc_s) begin
      err_count_s = sat_inc(err_count_r);
    end else begin
      err_count_s = err_count_r;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= RECV;
      acc_r       <= 1'b0;
      bit_cnt_r   <= '0;
      word_r      <= '0;
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
      err_count_r <= '0;
    end else begin
      state_r     <= state_s;
      acc_r       <= acc_s;
      bit_cnt_r   <= bit_cnt_s;
      word_r      <= word_s;
      out_data_r  <= out_data_s;
      out_err_r   <= out_err_s;
      err_count_r <= err_count_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == OUT);
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench: three checkers (even/8-bit count, odd, even/2-bit count) share one stimulus stream.
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_bit;
  logic out_ready;
  logic abort;
  logic clr_cnt;
  logic [7:0] cnt_e;
  logic [7:0] cnt_o;
  logic [1:0] cnt_s;
  int checks = 0;
  int errors = 0;

  parity_frame_checker_if #(.DATA_W(8)) bus_e ();
  parity_frame_checker_if #(.DATA_W(8)) bus_o ();
  parity_frame_checker_if #(.DATA_W(8)) bus_s ();

  assign bus_e.in_valid  = in_valid;
  assign bus_e.in_bit    = in_bit;
  assign bus_e.out_ready = out_ready;
  assign bus_o.in_valid  = in_valid;
  assign bus_o.in_bit    = in_bit;
  assign bus_o.out_ready = out_ready;
  assign bus_s.in_valid  = in_valid;
  assign bus_s.in_bit    = in_bit;
  assign bus_s.out_ready = out_ready;

  parity_frame_checker #(.DATA_W(8), .ODD(1'b0), .ERR_CNT_W(8)) u_even (
    .clk(clk), .rst_n(rst_n), .bus(bus_e), .abort(abort), .clr_cnt(clr_cnt), .err_count(cnt_e)
  );
  parity_frame_checker #(.DATA_W(8), .ODD(1'b1), .ERR_CNT_W(8)) u_odd (
    .clk(clk), .rst_n(rst_n), .bus(bus_o), .abort(abort), .clr_cnt(clr_cnt), .err_count(cnt_o)
  );
  parity_frame_checker #(.DATA_W(8), .ODD(1'b0), .ERR_CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .abort(abort), .clr_cnt(clr_cnt), .err_count(cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = d[i];
      step();
    end
  endtask

  task automatic send_par(input logic p);
    in_valid = 1'b1;
    in_bit   = p;
    step();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    out_ready = 1'b0; abort = 1'b0; clr_cnt = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(bus_e.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus_e.in_ready), 32'd1);
    chk("rst_out_data", 32'(bus_e.out_data), 32'h00);
    chk("rst_out_err", 32'(bus_e.out_err), 32'd0);
    chk("rst_err_count", 32'(cnt_e), 32'd0);
    rst_n = 1'b1;

    // Even parity, clean frame
    out_ready = 1'b1;
    send_data(8'hA5);
    send_par(1'b0);
    chk("clean_valid", 32'(bus_e.out_valid), 32'd1);
    chk("clean_in_ready", 32'(bus_e.in_ready), 32'd0);
    chk("clean_data", 32'(bus_e.out_data), 32'hA5);
    chk("clean_err", 32'(bus_e.out_err), 32'd0);
    chk("clean_count", 32'(cnt_e), 32'd0);
    chk("clean_odd_err", 32'(bus_o.out_err), 32'd1);
    step();
    chk("clean_valid_drop", 32'(bus_e.out_valid), 32'd0);
    chk("clean_ready_back", 32'(bus_e.in_ready), 32'd1);

    // Bad even frame; the same bits are clean under odd parity
    send_data(8'h07);
    send_par(1'b0);
    chk("bad_err", 32'(bus_e.out_err), 32'd1);
    chk("bad_count", 32'(cnt_e), 32'd1);
    chk("bad_data", 32'(bus_e.out_data), 32'h07);
    chk("odd_err", 32'(bus_o.out_err), 32'd0);
    chk("odd_count", 32'(cnt_o), 32'd1);
    step();

    // Backpressure: result held, offered bit refused until the handshake
    out_ready = 1'b0;
    send_data(8'h5A);
    send_par(1'b0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(bus_e.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus_e.in_ready), 32'd0);
      chk("bp_data", 32'(bus_e.out_data), 32'h5A);
      chk("bp_err", 32'(bus_e.out_err), 32'd0);
      step();
    end
    out_ready = 1'b1;
    chk("bp_valid_at_hs", 32'(bus_e.out_valid), 32'd1);
    chk("bp_ready_at_hs", 32'(bus_e.in_ready), 32'd0);
    step();
    chk("bp_valid_after_hs", 32'(bus_e.out_valid), 32'd0);
    chk("bp_ready_after_hs", 32'(bus_e.in_ready), 32'd1);
    send_data(8'h81);
    send_par(1'b0);
    chk("bp_next_data", 32'(bus_e.out_data), 32'h81);
    chk("bp_next_err", 32'(bus_e.out_err), 32'd0);
    step();

    // Abort after three data bits
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      step();
    end
    in_valid = 1'b0;
    abort    = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", 32'(bus_e.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus_e.in_ready), 32'd1);
    send_data(8'h3C);
    send_par(1'b0);
    chk("abort_frame_valid", 32'(bus_e.out_valid), 32'd1);
    chk("abort_frame_data", 32'(bus_e.out_data), 32'h3C);
    chk("abort_frame_err", 32'(bus_e.out_err), 32'd0);
    chk("abort_count", 32'(cnt_e), 32'd1);
    step();
    chk("abort_single_result", 32'(bus_e.out_valid), 32'd0);

    // Saturation on the 2-bit counter, then clear against a counted frame
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("clr_sat", 32'(cnt_s), 32'd0);
    chk("clr_even", 32'(cnt_e), 32'd0);
    for (int k = 0; k < 5; k++) begin
      send_data(8'h07);
      send_par(1'b0);
      chk("sat_count", 32'(cnt_s), (k < 2) ? 32'(k + 1) : 32'd3);
      chk("sat_even_count", 32'(cnt_e), 32'(k + 1));
      step();
    end
    send_data(8'h07);
    clr_cnt = 1'b1;
    send_par(1'b0);
    clr_cnt = 1'b0;
    chk("clr_race_sat", 32'(cnt_s), 32'd0);
    chk("clr_race_even", 32'(cnt_e), 32'd0);
    chk("clr_race_err", 32'(bus_s.out_err), 32'd1);
    chk("clr_race_odd", 32'(cnt_o), 32'd0);
    step();

    // Reset while holding a result
    out_ready = 1'b0;
    send_data(8'h07);
    send_par(1'b0);
    chk("pre_rst_valid", 32'(bus_e.out_valid), 32'd1);
    chk("pre_rst_count", 32'(cnt_e), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(bus_e.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus_e.out_data), 32'h00);
    chk("mid_rst_err", 32'(bus_e.out_err), 32'd0);
    chk("mid_rst_count", 32'(cnt_e), 32'd0);
    chk("mid_rst_in_ready", 32'(bus_e.in_ready), 32'd1);
    out_ready = 1'b1;
    send_data(8'hFF);
    send_par(1'b0);
    chk("post_rst_data", 32'(bus_e.out_data), 32'hFF);
    chk("post_rst_err", 32'(bus_e.out_err), 32'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

Serial-input frame checker that consumes a bit stream of `DATA_W` data bits followed by one parity bit. It accumulates XOR parity over each frame, emits the recovered word with a parity-error flag over a valid/ready handshake, and keeps a saturating error count. It sits directly downstream of the parity generator stages, on the receive side of the link.

## Interface
- `DATA_W`, 8: data bits per frame; must be ≥ 1.
- `ODD`, 0: 0 selects even parity, 1 selects odd parity.
- `ERR_CNT_W`, 8: width of the error counter; must be ≥ 1.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `in_valid`  input  1  `in_bit` is valid this cycle.
- `in_bit`  input  1  serial bit; data LSB first, then parity.
- `in_ready`  output  1  checker can accept a bit this cycle.
- `abort`  input  1  synchronous frame discard.
- `clr_cnt`  input  1  synchronous clear of `err_count`.
- `out_valid`  output  1  frame result available.
- `out_ready`  input  1  consumer accepts the result.
- `out_data`  output  DATA_W  recovered data word.
- `out_err`  output  1  parity error for `out_data`.
- `err_count`  output  ERR_CNT_W  saturating count of bad frames.

## Operation
- States: RECV (data bits), PAR (parity bit), OUT (result held).
- A bit is accepted only when `in_valid && in_ready`. `in_ready = (state != OUT)`, decoded from registered state.
- RECV:
  - On each accepted bit, `acc ^= in_bit` and the bit is shifted into the word at position `bit_cnt`, so data bit i lands in `out_data[i]`.
  - `bit_cnt` increments on each accepted bit. The accept at `bit_cnt == DATA_W-1` moves to PAR and resets `bit_cnt` to 0.
- PAR:
  - On the accepted bit `p`: `out_err <= acc ^ p ^ ODD`, `out_data` is loaded with the assembled word, and the state moves to OUT.
  - `err_count` increments on the same edge if the error is set. It saturates at all-ones and never wraps.
- OUT:
  - `out_valid = 1` and `out_data`/`out_err` are held stable.
  - When `out_ready` is high, return to RECV with `acc = 0`, `bit_cnt = 0` and `out_valid = 0`.
  - Input bits offered during OUT are not accepted; the upstream stage must hold them.
- `abort` in any state, on the next edge:
  - State goes to RECV, `acc` and `bit_cnt` are cleared, and `out_valid` drops.
  - Any pending result is discarded.
  - `err_count` is unaffected, except that an abort in PAR with a valid parity bit present discards that bit and does not count it.
- `abort` takes priority over `in_valid` and `out_ready`.
- `clr_cnt` sets `err_count` to 0 on the next edge. It takes priority over a simultaneous increment, so that frame is not counted.
- Reset (`rst_n` low at an edge) forces:
  - state RECV, `acc = 0`, `bit_cnt = 0`
  - `out_valid = 0`, `out_data = 0`, `out_err = 0`, `err_count = 0`
  - After the reset edge, `in_ready = 1`.
  - Reset mid-frame or in OUT discards everything.

## Timing
- Latency: `out_valid` rises on the edge that accepts the parity bit, so it is visible the cycle after that bit is presented.
- One frame costs DATA_W+1 accepted bits plus at least 1 OUT cycle. Maximum throughput is one frame per DATA_W+2 cycles.
- `out_valid` is held through any number of `out_ready`-low cycles, and stays asserted during the cycle `out_ready` is high. If `in_valid` is high in that same cycle, the bit is not accepted, because `in_ready` is still 0 there.
- The first bit of the next frame can be accepted on the cycle after the handshake.
- `err_count` updates on the same edge as `out_valid` rises.
- Gaps in `in_valid` do not disturb `acc` or `bit_cnt`.

## Test plan
- **Even parity, clean frame.** `DATA_W=8`, `ODD=0`: send 0xA5 LSB first, then parity 0, with `out_ready=1` → `out_valid` for 1 cycle, `out_data=0xA5`, `out_err=0`, `err_count=0`.
- **Even parity, bad frame, then odd parity.**
  - `DATA_W=8`, `ODD=0`: send 0x07 with parity 0 → `out_err=1`, `err_count=1`.
  - `ODD=1`: send 0x07 with parity 0 → `out_err=0`.
- **Backpressure.** Hold `out_ready=0` for 5 cycles after the result while `in_valid=1` → `in_ready=0` and the outputs are stable for those 5 cycles. Then raise `out_ready` → the handshake completes and the next frame's first bit is accepted the following cycle.
- **Abort mid-frame.** Assert `abort` after 3 data bits, then send a full 0x3C frame with parity 0 → a single result, `out_data=0x3C`, `out_err=0`, with no corruption from the aborted bits.
- **Counter saturation and clear.**
  - `ERR_CNT_W=2`: send 5 bad frames → `err_count` goes 1, 2, 3, 3, 3.
  - Then assert `clr_cnt` in the same cycle as a 6th bad frame's parity bit → `err_count=0`.
- **Reset mid-operation.** Pulse `rst_n` low for 1 cycle while in OUT → `out_valid=0`, `out_data=0`, `out_err=0`, `err_count=0`, and `in_ready=1` on the next cycle.
